frogger_round_ctrl: RTL and testbench
=====================================

# frogger_round_ctrl

Round sequencer for the Frogger game. It owns the time-bar width, the lives count, the five home-bay occupancy flags and the play/death/win/game-over state machine. It advances on one-cycle frame ticks from the VGA controller. Its outputs drive the renderer's time bar (replacing the fixed width of 200), frog respawn/freeze in the frog motion logic, and the status overlays.

## Interface
Parameters:
- TIME_MAX, 200: full time-bar width in pixels; reload value.
- FRAMES_PER_STEP, 30: frame ticks per 1-pixel time-bar decrement.
- LIVES_INIT, 3: lives at game start (≤7).
- DEATH_FRAMES, 60: frame ticks spent in the death animation.
- GOAL_SLOTS, 5: number of home bays (≤5).

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high; forces the IDLE values below.
- frame_tick  in  1  one-cycle pulse per frame (vsync).
- start  in  1  one-cycle pulse from the start key.
- collide  in  1  level; frog overlaps a hazard (car, or water with no log). Sampled only on frame_tick.
- goal_hit  in  1  one-cycle pulse; the frog reached the bay row.
- goal_idx  in  3  bay index, valid with goal_hit.
- time_width  out  10  current time-bar width in pixels.
- lives  out  3  remaining lives.
- goals_filled  out  5  bit i set = bay i occupied.
- frog_respawn  out  1  one-cycle pulse; frog logic reloads the start position.
- frog_freeze  out  1  level; frog input ignored.
- game_over  out  1  level; high in OVER.
- round_won  out  1  level; high in WIN.
- state  out  3  IDLE=0, PLAY=1, DYING=2, OVER=3, WIN=4.

## Operation
- Reset values:
  - state=IDLE, time_width=TIME_MAX, lives=LIVES_INIT, goals_filled=0.
  - frog_respawn=0, frog_freeze=1, game_over=0, round_won=0.
  - Internal frame_cnt=0, death_cnt=0.
- IDLE, OVER or WIN, on start:
  - reinitialise time_width, lives, goals_filled and the counters;
  - go to PLAY and pulse frog_respawn.
- PLAY: frog_freeze=0. On each frame_tick:
  - frame_cnt increments. At FRAMES_PER_STEP-1 it wraps to 0 and time_width decrements, saturating at 0.
  - If collide=1, or time_width=0 at that tick: go to DYING, lives decrements (saturates at 0), death_cnt=0.
- PLAY, on goal_hit with goal_idx<GOAL_SLOTS and that bay empty:
  - set goals_filled[goal_idx];
  - time_width=TIME_MAX, frame_cnt=0;
  - if all GOAL_SLOTS bits are now set, go to WIN;
  - otherwise pulse frog_respawn and stay in PLAY.
- PLAY, on goal_hit with goal_idx≥GOAL_SLOTS or the bay already filled: handled exactly as a death.
- Same cycle as a frame_tick death: goal_hit has priority. Collide is ignored that cycle and the time step is still applied.
- DYING: frog_freeze=1.
  - Each frame_tick increments death_cnt.
  - On the tick where death_cnt reaches DEATH_FRAMES-1: if lives=0, go to OVER; else go to PLAY with time_width=TIME_MAX, frame_cnt=0, and pulse frog_respawn.
- Ignored inputs:
  - start in PLAY or DYING.
  - goal_hit outside PLAY.
  - collide outside PLAY, or without frame_tick.
- frog_freeze=1 in IDLE, DYING, OVER and WIN.

## Timing
- All outputs are registered; each updates on the rising edge that samples its triggering input (1-cycle latency).
- frog_respawn is high for exactly one cycle, the cycle after the triggering edge. There are never two consecutive high cycles.
- Time-bar countdown, time_width from TIME_MAX to 0: TIME_MAX*FRAMES_PER_STEP frame ticks (6000 at defaults). The death is taken on the next tick.
- Asynchronous Reset, at any state or mid-count, returns all outputs to their reset values immediately. The first action after release requires start.
- frame_tick and start in the same cycle in IDLE: go to PLAY; that tick is not counted.

## Test plan
- Reset, then start → state=1 and frog_respawn high for 1 cycle. After 30 frame_ticks, time_width=199. After 6000 frame_ticks, time_width=0. Next tick → state=2, lives=2.
- PLAY, collide=1 on a frame_tick → DYING, lives=2, frog_freeze=1. After 60 frame_ticks → PLAY, time_width=200, one respawn pulse.
- Three deaths from LIVES_INIT=3 → after the third death animation, state=3, game_over=1, lives=0. start → PLAY, lives=3, goals_filled=0.
- goal_hit at idx 0,1,2,3 → goals_filled=01111, time_width=200 after each, four respawn pulses. goal_hit idx 4 → state=4, round_won=1.
- goal_hit idx 2 twice → second hit gives DYING with lives decremented. goal_hit idx 6 → DYING. goal_hit together with frame_tick+collide → goal taken, no death.
- Assert Reset mid-DYING with death_cnt=30 → immediately state=0, lives=3, time_width=200, frog_freeze=1. Then start while in PLAY → no effect.

Source files
------------

// File: rtl/frogger_round_ctrl.sv
// Frogger round sequencer: time bar, lives, home bays and the play/death/win/over FSM.
// Every output is registered and updates on the edge that samples its trigger.
module frogger_round_ctrl #(
  parameter int TIME_MAX        = 200,
  parameter int FRAMES_PER_STEP = 30,
  parameter int LIVES_INIT      = 3,
  parameter int DEATH_FRAMES    = 60,
  parameter int GOAL_SLOTS      = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       collide,
  input  logic       goal_hit,
  input  logic [2:0] goal_idx,
  output logic [9:0] time_width,
  output logic [2:0] lives,
  output logic [4:0] goals_filled,
  output logic       frog_respawn,
  output logic       frog_freeze,
  output logic       game_over,
  output logic       round_won,
  output logic [2:0] state
);

  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int DW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [9:0]    TW_MAX    = 10'(TIME_MAX);
  localparam logic [2:0]    LIVES0    = 3'(LIVES_INIT);
  localparam logic [4:0]    ALL_BAYS  = 5'((1 << GOAL_SLOTS) - 1);
  localparam logic [FW-1:0] FC_LAST   = FW'(FRAMES_PER_STEP - 1);
  localparam logic [DW-1:0] DC_LAST   = DW'(DEATH_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_DYING = 3'd2,
    S_OVER  = 3'd3,
    S_WIN   = 3'd4
  } state_t;

  state_t        r_state;
  logic [9:0]    r_tw;
  logic [2:0]    r_lives;
  logic [4:0]    r_goals;
  logic [FW-1:0] r_fc;
  logic [DW-1:0] r_dc;
  logic          r_respawn;
  logic          r_freeze;
  logic          r_over;
  logic          r_won;

  logic          w_goal_valid;
  logic [4:0]    w_goal_mask;
  logic          w_goal_new;
  logic [4:0]    w_goals_next;
  logic          w_all_filled;
  logic          w_tick_death;
  logic [9:0]    w_base_tw;
  logic [FW-1:0] w_base_fc;
  logic          w_wrap;
  logic [9:0]    w_tw_upd;
  logic [FW-1:0] w_fc_upd;
  logic [2:0]    w_lives_dec;

  assign w_goal_valid = int'(goal_idx) < GOAL_SLOTS;
  assign w_goal_mask  = 5'b00001 << goal_idx;
  assign w_goal_new   = goal_hit && w_goal_valid && ((r_goals & w_goal_mask) == 5'b0);
  assign w_goals_next = r_goals | w_goal_mask;
  assign w_all_filled = (w_goals_next & ALL_BAYS) == ALL_BAYS;
  assign w_tick_death = frame_tick && (collide || (r_tw == 10'd0));
  assign w_lives_dec  = (r_lives != 3'd0) ? r_lives - 3'd1 : 3'd0;

  // A scored goal reloads the bar first; a coincident frame tick is then counted on top.
  assign w_base_tw = w_goal_new ? TW_MAX : r_tw;
  assign w_base_fc = w_goal_new ? '0 : r_fc;
  assign w_wrap    = (w_base_fc == FC_LAST);
  assign w_tw_upd  = (frame_tick && w_wrap && (w_base_tw != 10'd0)) ? w_base_tw - 10'd1 : w_base_tw;
  assign w_fc_upd  = !frame_tick ? w_base_fc : (w_wrap ? '0 : w_base_fc + 1'b1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_tw      <= TW_MAX;
      r_lives   <= LIVES0;
      r_goals   <= 5'b0;
      r_fc      <= '0;
      r_dc      <= '0;
      r_respawn <= 1'b0;
      r_freeze  <= 1'b1;
      r_over    <= 1'b0;
      r_won     <= 1'b0;
    end else begin
      r_respawn <= 1'b0;
      case (r_state)
        S_PLAY: begin
          r_tw <= w_tw_upd;
          r_fc <= w_fc_upd;
          if (w_goal_new) begin
            r_goals <= w_goals_next;
            if (w_all_filled) begin
              r_state  <= S_WIN;
              r_won    <= 1'b1;
              r_freeze <= 1'b1;
            end else begin
              // Frog is already reloading this cycle; never stretch the pulse.
              r_respawn <= !r_respawn;
            end
          end else if (goal_hit || w_tick_death) begin
            r_state  <= S_DYING;
            r_lives  <= w_lives_dec;
            r_dc     <= '0;
            r_freeze <= 1'b1;
          end
        end
        S_DYING: begin
          if (frame_tick) begin
            if (r_dc == DC_LAST) begin
              if (r_lives == 3'd0) begin
                r_state <= S_OVER;
                r_over  <= 1'b1;
              end else begin
                r_state   <= S_PLAY;
                r_tw      <= TW_MAX;
                r_fc      <= '0;
                r_respawn <= 1'b1;
                r_freeze  <= 1'b0;
              end
            end else begin
              r_dc <= r_dc + 1'b1;
            end
          end
        end
        S_IDLE, S_OVER, S_WIN: begin
          if (start) begin
            r_state   <= S_PLAY;
            r_tw      <= TW_MAX;
            r_lives   <= LIVES0;
            r_goals   <= 5'b0;
            r_fc      <= '0;
            r_dc      <= '0;
            r_respawn <= 1'b1;
            r_freeze  <= 1'b0;
            r_over    <= 1'b0;
            r_won     <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_freeze <= 1'b1;
        end
      endcase
    end
  end

  assign time_width   = r_tw;
  assign lives        = r_lives;
  assign goals_filled = r_goals;
  assign frog_respawn = r_respawn;
  assign frog_freeze  = r_freeze;
  assign game_over    = r_over;
  assign round_won    = r_won;
  assign state        = r_state;

endmodule

// File: tb/tb_frogger_round_ctrl.sv
// Self-checking bench for frogger_round_ctrl: directed scenarios plus a randomized run
// compared cycle by cycle against a plain-arithmetic model of the game rules.
module tb_frogger_round_ctrl;

  localparam int TM = 200, FPS = 30, LIV = 3, DF = 60, SLOTS = 5;
  localparam int M_IDLE = 0, M_PLAY = 1, M_DYING = 2, M_OVER = 3, M_WIN = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0, start = 1'b0, collide = 1'b0, goal_hit = 1'b0;
  logic [2:0] goal_idx = 3'd0;
  logic [9:0] time_width;
  logic [2:0] lives;
  logic [4:0] goals_filled;
  logic       frog_respawn, frog_freeze, game_over, round_won;
  logic [2:0] state;
  logic [24:0] dut_vec;

  frogger_round_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start), .collide(collide),
    .goal_hit(goal_hit), .goal_idx(goal_idx), .time_width(time_width), .lives(lives),
    .goals_filled(goals_filled), .frog_respawn(frog_respawn), .frog_freeze(frog_freeze),
    .game_over(game_over), .round_won(round_won), .state(state)
  );

  always #5 Clk = ~Clk;

  assign dut_vec = {state, time_width, lives, goals_filled, frog_respawn, frog_freeze, game_over, round_won};

  int n_checks = 0, n_fail = 0, resp_count = 0;
  int m_state, m_tw, m_lives, m_goals, m_fc, m_dc;
  bit m_resp;

  function automatic void model_reset();
    m_state = M_IDLE; m_tw = TM; m_lives = LIV; m_goals = 0; m_fc = 0; m_dc = 0; m_resp = 1'b0;
  endfunction

  function automatic void model_update(bit ft, bit st, bit col, bit gh, int gi);
    bit resp = 1'b0;
    bit ok;
    int tw0 = m_tw;
    case (m_state)
      M_PLAY: begin
        ok = gh && gi < SLOTS && ((m_goals >> gi) & 1) == 0;
        if (ok) begin m_goals = m_goals | (1 << gi); m_tw = TM; m_fc = 0; end
        if (ft) begin
          m_fc++;
          if (m_fc == FPS) begin m_fc = 0; if (m_tw > 0) m_tw--; end
        end
        if (ok) begin
          if (m_goals == (1 << SLOTS) - 1) m_state = M_WIN;
          else resp = !m_resp;
        end else if (gh || (ft && (col || tw0 == 0))) begin
          m_state = M_DYING;
          if (m_lives > 0) m_lives--;
          m_dc = 0;
        end
      end
      M_DYING: if (ft) begin
        m_dc++;
        if (m_dc == DF) begin
          if (m_lives == 0) m_state = M_OVER;
          else begin m_state = M_PLAY; m_tw = TM; m_fc = 0; resp = 1'b1; end
        end
      end
      default: if (st) begin
        m_state = M_PLAY; m_tw = TM; m_lives = LIV; m_goals = 0; m_fc = 0; m_dc = 0; resp = 1'b1;
      end
    endcase
    m_resp = resp;
  endfunction

  function automatic logic [24:0] exp_vec();
    return {3'(m_state), 10'(m_tw), 3'(m_lives), 5'(m_goals), m_resp,
            m_state != M_PLAY, m_state == M_OVER, m_state == M_WIN};
  endfunction

  task automatic step(input bit ft, input bit st, input bit col, input bit gh, input int gi);
    frame_tick = ft; start = st; collide = col; goal_hit = gh; goal_idx = 3'(gi);
    @(posedge Clk);
    model_update(ft, st, col, gh, gi);
    #1;
    frame_tick = 1'b0; start = 1'b0; collide = 1'b0; goal_hit = 1'b0;
    if (frog_respawn) resp_count++;
  endtask

  task automatic tick();  step(1'b1, 1'b0, 1'b0, 1'b0, 0); endtask
  task automatic idle();  step(1'b0, 1'b0, 1'b0, 1'b0, 0); endtask
  task automatic goal(input int gi); step(1'b0, 1'b0, 1'b0, 1'b1, gi); endtask

  task automatic gappy_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) idle();
      tick();
    end
  endtask

  task automatic restart();
    Reset = 1'b1; @(posedge Clk); #1; Reset = 1'b0;
    model_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1; model_reset();
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++; if (time_width !== 10'd200) begin n_fail++; $display("FAIL reset_tw: got %0d want 200", time_width); end
    n_checks++; if (lives !== 3'd3) begin n_fail++; $display("FAIL reset_lives: got %0d want 3", lives); end
    n_checks++; if (goals_filled !== 5'b0) begin n_fail++; $display("FAIL reset_goals: got %b want 00000", goals_filled); end
    n_checks++; if ({frog_respawn, frog_freeze, game_over, round_won} !== 4'b0100) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0100", {frog_respawn, frog_freeze, game_over, round_won}); end
    Reset = 1'b0;
    idle(); idle();
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL idle_needs_start: got %0d want 0", state); end
  endtask

  task automatic test_countdown();
    resp_count = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    n_checks++; if (state !== 3'd1 || frog_respawn !== 1'b1 || time_width !== 10'd200) begin
      n_fail++; $display("FAIL start_play: got st=%0d resp=%b tw=%0d want 1 1 200", state, frog_respawn, time_width); end
    idle();
    n_checks++; if (frog_respawn !== 1'b0) begin n_fail++; $display("FAIL start_pulse_len: got %b want 0", frog_respawn); end
    gappy_ticks(30);
    n_checks++; if (time_width !== 10'd199) begin n_fail++; $display("FAIL tw_after_30: got %0d want 199", time_width); end
    repeat (TM * FPS - 30) tick();
    n_checks++; if (time_width !== 10'd0 || state !== 3'd1) begin
      n_fail++; $display("FAIL tw_after_6000: got tw=%0d st=%0d want 0 1", time_width, state); end
    tick();
    n_checks++; if (state !== 3'd2 || lives !== 3'd2 || frog_freeze !== 1'b1) begin
      n_fail++; $display("FAIL timeout_death: got st=%0d lives=%0d frz=%b want 2 2 1", state, lives, frog_freeze); end
    repeat (DF - 1) tick();
    n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL dying_len: got %0d want 2", state); end
    tick();
    n_checks++; if (state !== 3'd1 || time_width !== 10'd200 || frog_respawn !== 1'b1) begin
      n_fail++; $display("FAIL death_respawn: got st=%0d tw=%0d resp=%b want 1 200 1", state, time_width, frog_respawn); end
    idle();
    n_checks++; if (resp_count != 2 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL countdown_end: got resp=%0d vec=%h want 2 %h", resp_count, dut_vec, exp_vec()); end
  endtask

  task automatic test_collide_deaths();
    restart();
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL collide_no_tick: got %0d want 1", state); end
    for (int d = 1; d <= 3; d++) begin
      gappy_ticks($urandom_range(1, 40));
      step(1'b1, 1'b0, 1'b1, 1'b0, 0);
      n_checks++; if (state !== 3'd2 || lives !== 3'(3 - d) || frog_freeze !== 1'b1) begin
        n_fail++; $display("FAIL collide_death%0d: got st=%0d lives=%0d frz=%b want 2 %0d 1", d, state, lives, frog_freeze, 3 - d); end
      gappy_ticks(DF);
    end
    n_checks++; if (state !== 3'd3 || game_over !== 1'b1 || lives !== 3'd0) begin
      n_fail++; $display("FAIL game_over: got st=%0d over=%b lives=%0d want 3 1 0", state, game_over, lives); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    n_checks++; if (state !== 3'd1 || lives !== 3'd3 || goals_filled !== 5'b0 || game_over !== 1'b0) begin
      n_fail++; $display("FAIL restart_from_over: got st=%0d lives=%0d goals=%b want 1 3 00000", state, lives, goals_filled); end
  endtask

  task automatic test_goals();
    int order[4] = '{0, 1, 2, 3};
    logic [4:0] exp_goals = 5'b0;
    for (int i = 3; i > 0; i--) begin
      int j = int'($urandom_range(0, i));
      int t = order[i]; order[i] = order[j]; order[j] = t;
    end
    restart();
    resp_count = 0;
    for (int k = 0; k < 4; k++) begin
      gappy_ticks($urandom_range(1, 40));
      idle();
      goal(order[k]);
      exp_goals[order[k]] = 1'b1;
      n_checks++; if (goals_filled !== exp_goals || time_width !== 10'd200 || state !== 3'd1) begin
        n_fail++; $display("FAIL goal%0d: got goals=%b tw=%0d st=%0d want %b 200 1", order[k], goals_filled, time_width, state, exp_goals); end
      idle();
    end
    n_checks++; if (resp_count != 4 || goals_filled !== 5'b01111) begin
      n_fail++; $display("FAIL four_goals: got resp=%0d goals=%b want 4 01111", resp_count, goals_filled); end
    goal(4);
    n_checks++; if (state !== 3'd4 || round_won !== 1'b1 || frog_freeze !== 1'b1 || frog_respawn !== 1'b0) begin
      n_fail++; $display("FAIL win: got st=%0d won=%b frz=%b resp=%b want 4 1 1 0", state, round_won, frog_freeze, frog_respawn); end
  endtask

  task automatic test_bad_goals();
    restart();
    gappy_ticks(5);
    goal(2); idle();
    goal(2);
    n_checks++; if (state !== 3'd2 || lives !== 3'd2 || goals_filled !== 5'b00100) begin
      n_fail++; $display("FAIL repeat_bay: got st=%0d lives=%0d goals=%b want 2 2 00100", state, lives, goals_filled); end
    gappy_ticks(DF);
    idle();
    goal(6);
    n_checks++; if (state !== 3'd2 || lives !== 3'd1) begin
      n_fail++; $display("FAIL bad_idx: got st=%0d lives=%0d want 2 1", state, lives); end
    gappy_ticks(DF);
    idle();
    step(1'b1, 1'b0, 1'b1, 1'b1, 3);
    n_checks++; if (state !== 3'd1 || goals_filled !== 5'b01100 || lives !== 3'd1 || time_width !== 10'd200) begin
      n_fail++; $display("FAIL goal_beats_collide: got st=%0d goals=%b lives=%0d tw=%0d want 1 01100 1 200", state, goals_filled, lives, time_width); end
  endtask

  task automatic test_reset_mid_dying();
    restart();
    step(1'b1, 1'b0, 1'b1, 1'b0, 0);
    repeat (30) tick();
    #2 Reset = 1'b1;
    #1;
    n_checks++; if (state !== 3'd0 || lives !== 3'd3 || time_width !== 10'd200 || frog_freeze !== 1'b1 || goals_filled !== 5'b0) begin
      n_fail++; $display("FAIL async_reset: got st=%0d lives=%0d tw=%0d frz=%b want 0 3 200 1", state, lives, time_width, frog_freeze); end
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    tick();
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL post_reset_idle: got %0d want 0", state); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(); tick();
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    n_checks++; if (state !== 3'd1 || frog_respawn !== 1'b0 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL start_in_play: got st=%0d resp=%b vec=%h want 1 0 %h", state, frog_respawn, dut_vec, exp_vec()); end
  endtask

  task automatic test_random();
    int bad = 0;
    restart();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 11) == 0, int'($urandom_range(0, 7)));
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        if (bad < 10) $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec, exp_vec());
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_collide_deaths();
    test_goals();
    test_bad_goals();
    test_reset_mid_dying();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
